// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker fetch path.
package tinker_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC = 64'h2000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    FS_HOLD  = 1'b0,
    FS_FETCH = 1'b1
  } fetch_state_e;

  // Word-align a PC by clearing the byte-offset bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/tinker_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decoder port and redirect port.
interface tinker_fetch_unit_if
  import tinker_pkg::*;
();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/tinker_fetch_fifo.sv
// Instruction buffer: sync FIFO of fetch entries with flush and a registered head.
module tinker_fetch_fifo
  import tinker_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_valid,
  output fetch_entry_t           o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_wr_ptr_next;
  logic [PW-1:0] w_rd_ptr_next;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_count_next;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_head_next;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_pop   = i_pop && (w_count != '0) && !i_flush;
  // A full buffer may still accept a push when its head leaves in the same cycle.
  assign w_push  = i_push && !i_flush && ((w_count != PW'(DEPTH)) || w_pop);

  // Next pointers and next head; the new head is either already stored or arriving now.
  always_comb begin
    w_wr_ptr_next = r_wr_ptr + PW'(w_push);
    w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
    w_count_next  = w_wr_ptr_next - w_rd_ptr_next;
    w_head_next   = '0;
    if (i_flush) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_count_next  = '0;
    end else if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
        w_head_next = i_push_data;
      end else begin
        w_head_next = r_mem[w_rd_ptr_next[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
      o_valid  <= 1'b0;
      o_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      o_count  <= w_count_next;
      o_valid  <= (w_count_next != '0);
      o_head   <= w_head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/tinker_fetch_unit.sv
// Instruction fetch stage: PC/request issue with credit control, response tracking,
// redirect flush with stale-response dropping, and a buffered decoder port.
module tinker_fetch_unit
  import tinker_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tinker_fetch_unit_if.master bus
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  w_rsp_pc_next;
  logic [OUT_W-1:0] r_outstanding;
  logic [OUT_W-1:0] r_drop;
  logic [OUT_W-1:0] w_outstanding_next;
  logic [OUT_W-1:0] w_drop_next;

  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_valid;
  fetch_entry_t     w_fifo_head;
  fetch_entry_t     w_push_entry;

  logic             w_redirect;
  logic             w_rsp;
  logic [31:0]      w_credit_used;
  logic             w_credit_ok;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_push;
  logic             w_pop;

  assign w_redirect = bus.redirect_valid;
  // Responses with nothing in flight are protocol errors and are ignored.
  assign w_rsp      = bus.imem_rsp_valid && (r_outstanding != '0);

  // Live in-flight requests plus buffered entries must leave room for every live response.
  assign w_credit_used = 32'(r_outstanding) - 32'(r_drop) + 32'(w_fifo_count);
  assign w_credit_ok   = (r_outstanding < OUT_W'(MAX_OUTSTANDING))
                      && (w_credit_used < 32'(FIFO_DEPTH));
  assign w_req_valid   = (r_state == FS_FETCH) && !w_redirect && w_credit_ok;
  assign w_req_fire    = w_req_valid && bus.imem_req_ready;

  assign w_pop        = w_fifo_valid && bus.inst_ready;
  assign w_push       = w_rsp && (r_drop == '0) && !w_redirect;
  assign w_push_entry = '{pc: r_rsp_pc, inst: bus.imem_rsp_data};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = w_fifo_valid;
  assign bus.inst_data      = w_fifo_head.inst;
  assign bus.inst_pc        = w_fifo_head.pc;

  tinker_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_count     (w_fifo_count),
    .o_valid     (w_fifo_valid),
    .o_head      (w_fifo_head)
  );

  // Next state: FS_HOLD keeps requests off for the first cycle out of reset.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_rsp_pc_next      = r_rsp_pc;
    w_outstanding_next = r_outstanding;
    w_drop_next        = r_drop;

    case (r_state)
      FS_HOLD:  w_state_next = FS_FETCH;
      FS_FETCH: w_state_next = FS_FETCH;
      default:  w_state_next = FS_HOLD;
    endcase

    if (w_redirect) begin
      w_pc_next          = align_pc(bus.redirect_pc);
      w_rsp_pc_next      = align_pc(bus.redirect_pc);
      w_outstanding_next = r_outstanding - OUT_W'(w_rsp);
      w_drop_next        = r_outstanding - OUT_W'(w_rsp);
    end else begin
      if (w_req_fire) begin
        w_pc_next = r_pc + PC_STEP;
      end
      w_outstanding_next = r_outstanding + OUT_W'(w_req_fire) - OUT_W'(w_rsp);
      if (w_rsp) begin
        if (r_drop != '0) begin
          w_drop_next = r_drop - OUT_W'(1);
        end else begin
          w_rsp_pc_next = r_rsp_pc + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= FS_HOLD;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_rsp_pc      <= w_rsp_pc_next;
      r_outstanding <= w_outstanding_next;
      r_drop        <= w_drop_next;
    end
  end

  a_rsp_has_credit: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rsp_valid |-> (r_outstanding != '0)
  );

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed bench for tinker_fetch_unit with an in-order memory model and instruction scoreboard.
module tb_tinker_fetch_unit;
  import tinker_pkg::*;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tinker_fetch_unit_if bus ();

  tinker_fetch_unit #(
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           lat = 1;
  int           n_req = 0;
  int           n_pop = 0;
  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [63:0]  exp_req_addr = 64'h2000;
  logic [63:0]  last_req_addr = '1;
  logic [63:0]  last_pop_pc = '1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = a[31:0];
    hi = a[63:32];
    return lo ^ hi ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, check the scoreboard, then advance models at the edge.
  task automatic cycle();
    logic        fire_req;
    logic        fire_inst;
    logic        rsp;
    logic        redir;
    logic [63:0] raddr;
    logic [63:0] rpc;
    fetch_entry_t e;
    if (mem_q.size() > 0 && cyc >= mem_q[0].due) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    fire_req  = bus.imem_req_valid && bus.imem_req_ready;
    fire_inst = bus.inst_valid && bus.inst_ready;
    rsp       = bus.imem_rsp_valid;
    redir     = bus.redirect_valid;
    raddr     = bus.imem_req_addr;
    rpc       = bus.redirect_pc & ~64'h3;
    if (redir) chk("req_in_redirect", 64'(bus.imem_req_valid), 64'd0);
    if (fire_req) chk("req_addr", raddr, exp_req_addr);
    if (fire_inst) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL inst_unexpected: observed pc=%0h expected no instruction", bus.inst_pc);
        end
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", bus.inst_pc, e.pc);
        chk("inst_data", 64'(bus.inst_data), 64'(e.inst));
      end
      n_pop++;
      last_pop_pc = bus.inst_pc;
    end
    @(posedge clk);
    if (rsp) void'(mem_q.pop_front());
    if (redir) begin
      exp_q.delete();
      exp_req_addr = rpc;
    end
    if (fire_req) begin
      mem_q.push_back('{addr: raddr, due: cyc + lat});
      exp_q.push_back('{pc: raddr, inst: mem_word(raddr)});
      exp_req_addr  = raddr + 64'd4;
      last_req_addr = raddr;
      n_req++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    mem_q.delete();
    exp_q.delete();
    exp_req_addr = 64'h2000;
    @(posedge clk);
    @(negedge clk);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_req_addr", bus.imem_req_addr, 64'h2000);
    chk("rst_inst_data", 64'(bus.inst_data), 64'd0);
    chk("rst_inst_pc", bus.inst_pc, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int r0;
    logic [63:0] exp_drop;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    // Streaming at latency 1 reaches one instruction per cycle.
    lat = 1;
    do_reset();
    for (int i = 0; i < 40 && n_pop == 0; i++) cycle();
    chk("t1_first_pc", last_pop_pc, 64'h2000);
    p0 = n_pop;
    repeat (16) cycle();
    chk("t1_throughput", 64'(n_pop - p0), 64'd16);

    // Stalled decoder: exactly four requests, then drain in order.
    bus.inst_ready = 1'b0;
    do_reset();
    r0 = n_req;
    repeat (12) cycle();
    chk("t2_req_count", 64'(n_req - r0), 64'd4);
    chk("t2_req_valid_low", 64'(bus.imem_req_valid), 64'd0);
    chk("t2_inst_valid", 64'(bus.inst_valid), 64'd1);
    bus.inst_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 20 && (n_pop - p0) < 4; i++) cycle();
    chk("t2_last_drain_pc", last_pop_pc, 64'h200C);
    repeat (6) cycle();

    // Redirect with two responses in flight at latency 3.
    lat = 3;
    do_reset();
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) cycle();
    chk("t3_inflight", 64'(dut.r_outstanding), 64'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3002;
    r0 = n_req;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("t3_drop", 64'(dut.r_drop), 64'd2);
    chk("t3_flushed", 64'(bus.inst_valid), 64'd0);
    for (int i = 0; i < 20 && n_req == r0; i++) cycle();
    chk("t3_first_req", last_req_addr, 64'h3000);
    p0 = n_pop;
    for (int i = 0; i < 30 && n_pop == p0; i++) cycle();
    chk("t3_first_pc", last_pop_pc, 64'h3000);
    repeat (8) cycle();

    // Memory back-pressure holds the request address.
    lat = 1;
    do_reset();
    r0 = n_req;
    for (int i = 0; i < 20 && (n_req - r0) < 2; i++) cycle();
    bus.imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("t4_req_addr", bus.imem_req_addr, 64'h2008);
    end
    chk("t4_outstanding", 64'(dut.r_outstanding), 64'(mem_q.size()));
    chk("t4_req_total", 64'(n_req - r0), 64'd2);
    bus.imem_req_ready = 1'b1;
    repeat (6) cycle();

    // Reset while the buffer is full.
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (12) cycle();
    chk("t5_full_valid", 64'(bus.inst_valid), 64'd1);
    chk("t5_full_noreq", 64'(bus.imem_req_valid), 64'd0);
    do_reset();
    bus.inst_ready = 1'b1;
    r0 = n_req;
    for (int i = 0; i < 20 && n_req == r0; i++) cycle();
    chk("t5_first_req", last_req_addr, 64'h2000);
    repeat (6) cycle();

    // Redirect coinciding with a response and a pop; new PC wraps at 2^64.
    lat = 2;
    do_reset();
    for (int i = 0; i < 30 && n_pop < 3; i++) cycle();
    for (int i = 0; i < 20 && !(bus.inst_valid && mem_q.size() > 0 && mem_q[0].due <= cyc); i++)
      cycle();
    exp_drop = 64'(mem_q.size()) - 64'd1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF9;
    p0 = n_pop;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("t6_redirect_pop", 64'(n_pop - p0), 64'd1);
    chk("t6_drop", 64'(dut.r_drop), exp_drop);
    chk("t6_flushed", 64'(bus.inst_valid), 64'd0);
    p0 = n_pop;
    for (int i = 0; i < 30 && n_pop == p0; i++) cycle();
    chk("t6_first_pc", last_pop_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 30 && (n_pop - p0) < 3; i++) cycle();
    chk("t6_wrap_pc", last_pop_pc, 64'h0);
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
